// File: rtl/switch_pio_ctrl_pkg.sv
// Shared register map and edge-mode encodings for the switch PIO controller.
package switch_pio_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RAW  = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  // A debounced bit always flips towards its synced value, so that value is the new level.
  function automatic logic edge_hit(input int mode, input logic flip, input logic new_level);
    case (mode)
      EDGE_FALLING: return flip & ~new_level;
      EDGE_BOTH:    return flip;
      default:      return flip & new_level;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchronizer, stability counter and debounced flop.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic synced,
  output logic debounced,
  output logic flip
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic [CNT_W-1:0] count;

  // Combinational so edge capture in the parent lands on the same edge as the flip.
  assign flip = (synced != debounced) && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= 1'b0;
      synced    <= 1'b0;
      debounced <= 1'b0;
      count     <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
      if (synced == debounced) begin
        count <= '0;
      end else if (flip) begin
        debounced <= synced;
        count     <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_pio_ctrl.sv
// Avalon-MM switch PIO: debounced inputs, maskable edge-capture interrupt.
module switch_pio_ctrl
  import switch_pio_ctrl_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("switch_pio_ctrl: WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("switch_pio_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end
  if (EDGE_MODE < EDGE_RISING || EDGE_MODE > EDGE_BOTH) begin : g_bad_edge_mode
    $error("switch_pio_ctrl: EDGE_MODE must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;
  logic             wr_access;
  logic             rd_access;
  logic             unused_wr_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw      (in_port[i]),
      .synced   (synced[i]),
      .debounced(debounced[i]),
      .flip     (flip[i])
    );
  end

  // Bits of writedata above WIDTH-1 are ignored by every register.
  assign wdata          = writedata[WIDTH-1:0];
  assign unused_wr_bits = ^writedata;
  assign wr_access      = chipselect & write;
  assign rd_access      = chipselect & ~write;

  always_comb begin
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = edge_hit(EDGE_MODE, flip[i], synced[i]);
    end
  end

  assign edge_clr = (wr_access && address == ADDR_EDGE) ? wdata : '0;

  // A set on the same edge as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_access && address == ADDR_MASK) begin
      irq_mask <= wdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = debounced;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_RAW:  rd_mux[WIDTH-1:0] = synced;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_access) begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
